// File: rtl/conv_window_3x3.sv
// rtl/conv_window_3x3.sv - 3x3 sliding window generator over a raster pixel stream
// Two row line buffers feed a shift array; windows are emitted only when fully inside the image.
module conv_window_3x3 #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 224,
  parameter int IMG_H  = 224,
  parameter int COL_W  = 8,
  parameter int ROW_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic signed [DATA_W-1:0] win0,
  output logic signed [DATA_W-1:0] win1,
  output logic signed [DATA_W-1:0] win2,
  output logic signed [DATA_W-1:0] win3,
  output logic signed [DATA_W-1:0] win4,
  output logic signed [DATA_W-1:0] win5,
  output logic signed [DATA_W-1:0] win6,
  output logic signed [DATA_W-1:0] win7,
  output logic signed [DATA_W-1:0] win8,
  output logic                     out_valid,
  output logic                     frame_done
);

  localparam int AW = $clog2(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [DATA_W-1:0] lb_a [IMG_W];
  logic [DATA_W-1:0] lb_b [IMG_W];
  logic [DATA_W-1:0] lb_a_rd;
  logic [DATA_W-1:0] lb_b_rd;

  // Only the two older columns are stored; the newest column goes straight to the outputs.
  logic [DATA_W-1:0] taps [3][2];

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [AW-1:0]    addr;
  logic             col_last;
  logic             row_last;
  logic             emit;

  assign addr     = col[AW-1:0];
  assign lb_a_rd  = lb_a[addr];
  assign lb_b_rd  = lb_b[addr];
  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign emit     = (row >= ROW_TWO) && (col >= COL_TWO);

  // Line buffers are never reset; stale contents are masked by the row gate on emit.
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      lb_b[addr] <= lb_a_rd;
      lb_a[addr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      win0 <= '0; win1 <= '0; win2 <= '0;
      win3 <= '0; win4 <= '0; win5 <= '0;
      win6 <= '0; win7 <= '0; win8 <= '0;
      for (int r = 0; r < 3; r++) begin
        taps[r][0] <= '0;
        taps[r][1] <= '0;
      end
    end else if (in_valid) begin
      taps[0][0] <= taps[0][1];
      taps[0][1] <= lb_b_rd;
      taps[1][0] <= taps[1][1];
      taps[1][1] <= lb_a_rd;
      taps[2][0] <= taps[2][1];
      taps[2][1] <= in_data;

      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end

      out_valid  <= emit;
      frame_done <= emit && col_last && row_last;
      if (emit) begin
        win0 <= taps[0][0]; win1 <= taps[0][1]; win2 <= lb_b_rd;
        win3 <= taps[1][0]; win4 <= taps[1][1]; win5 <= lb_a_rd;
        win6 <= taps[2][0]; win7 <= taps[2][1]; win8 <= in_data;
      end
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_3x3.sv
// tb/tb_conv_window_3x3.sv - directed bench for conv_window_3x3 on a 5x4 image
module tb_conv_window_3x3;
  localparam int DW = 16;
  localparam int W  = 5;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [DW-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic          out_valid;
  logic          frame_done;
  logic [DW-1:0] win [9];

  int n_checks = 0;
  int n_err    = 0;
  int wins;
  int dones;
  logic [DW-1:0] last_exp [9];

  conv_window_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .COL_W(8), .ROW_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .win0(win0), .win1(win1), .win2(win2), .win3(win3), .win4(win4),
    .win5(win5), .win6(win6), .win7(win7), .win8(win8),
    .out_valid(out_valid), .frame_done(frame_done)
  );

  assign win[0] = win0; assign win[1] = win1; assign win[2] = win2;
  assign win[3] = win3; assign win[4] = win4; assign win[5] = win5;
  assign win[6] = win6; assign win[7] = win7; assign win[8] = win8;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: base + row*16 + col; mode 1: alternating signed extremes by raster index
  function automatic logic [DW-1:0] px(input int mode, input int base, input int r, input int c);
    if (mode == 1) return (((r * W + c) % 2) != 0) ? 16'h8000 : 16'h7FFF;
    return DW'(base + r * 16 + c);
  endfunction

  task automatic idle_step();
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    @(posedge clk);
    #1;
    check("idle_out_valid", out_valid, 0);
    check("idle_frame_done", frame_done, 0);
    for (int k = 0; k < 9; k++) check($sformatf("hold_win%0d", k), win[k], last_exp[k]);
  endtask

  task automatic pix_step(input int mode, input int base, input int r, input int c);
    logic exp_v;
    logic exp_d;
    in_valid = 1'b1;
    in_data  = px(mode, base, r, c);
    @(posedge clk);
    #1;
    exp_v = (r >= 2) && (c >= 2);
    exp_d = (r == H - 1) && (c == W - 1);
    check($sformatf("out_valid_r%0d_c%0d", r, c), out_valid, exp_v);
    check($sformatf("frame_done_r%0d_c%0d", r, c), frame_done, exp_d);
    if (out_valid) wins++;
    if (frame_done) dones++;
    if (exp_v) begin
      for (int k = 0; k < 9; k++) begin
        last_exp[k] = px(mode, base, r - 2 + k / 3, c - 2 + k % 3);
        check($sformatf("win%0d_r%0d_c%0d", k, r, c), win[k], last_exp[k]);
      end
    end
  endtask

  task automatic run_frame(input int mode, input int base, input bit gaps, input int npix);
    int idx;
    idx = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (idx < npix) begin
          pix_step(mode, base, r, c);
          if (gaps && (idx % 3 == 1)) begin
            idle_step();
            idle_step();
          end
        end
        idx++;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_frame_done", frame_done, 0);
    for (int k = 0; k < 9; k++) begin
      check($sformatf("reset_win%0d", k), win[k], 0);
      last_exp[k] = '0;
    end
    rst = 1'b0;

    // basic frame, continuous input
    wins = 0; dones = 0;
    run_frame(0, 0, 1'b0, W * H);
    check("basic_window_count", wins, 6);
    check("basic_frame_done_count", dones, 1);
    idle_step();
    idle_step();

    // same frame with bubbles
    wins = 0; dones = 0;
    run_frame(0, 0, 1'b1, W * H);
    check("bubble_window_count", wins, 6);
    check("bubble_frame_done_count", dones, 1);

    // back-to-back frames with no gap
    wins = 0; dones = 0;
    run_frame(0, 0, 1'b0, W * H);
    run_frame(0, 'h80, 1'b0, W * H);
    check("b2b_window_count", wins, 12);
    check("b2b_frame_done_count", dones, 2);

    // reset after pixel 0x23 with a pixel offered during reset
    run_frame(0, 0, 1'b0, 14);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h5555;
    @(posedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_frame_done", frame_done, 0);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) last_exp[k] = '0;
    idle_step();
    wins = 0; dones = 0;
    run_frame(0, 0, 1'b0, W * H);
    check("midrst_window_count", wins, 6);
    check("midrst_frame_done_count", dones, 1);

    // signed extremes
    wins = 0; dones = 0;
    run_frame(1, 0, 1'b0, W * H);
    check("signed_window_count", wins, 6);
    check("signed_frame_done_count", dones, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/conv_window_3x3.md
Name: conv_window_3x3

Overview:
- Producer side of the 9-operand datapath: turns a raster-order pixel stream into 3x3 windows that feed the nine multipliers ahead of the 9-input pipelined adder tree.
- One pixel is accepted per valid cycle. Two line buffers hold the previous two rows.
- A window is emitted only when it lies fully inside the image (valid padding, stride 1).
- Outputs are registered and timed so the downstream multiply/accumulate path needs no extra alignment.

Parameters:
- DATA_W, 16, signed pixel/activation width.
- IMG_W, 224, pixels per row (>= 3).
- IMG_H, 224, rows per frame (>= 3).
- COL_W, 8, width of column counter; must satisfy 2**COL_W >= IMG_W.
- ROW_W, 8, width of row counter; must satisfy 2**ROW_W >= IMG_H.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is accepted this cycle. There is no backpressure; the block always accepts.
- in_data  input  DATA_W  signed pixel, raster order (row-major, column 0 first).
- win0..win8  output  DATA_W each  window: win0 = (r-2,c-2), win1 = (r-2,c-1), win2 = (r-2,c), win3 = (r-1,c-2) ... win8 = (r,c).
- out_valid  output  1  win0..win8 hold a new window this cycle (single-cycle pulse per window).
- frame_done  output  1  one-cycle pulse coincident with the last out_valid of a frame.

Behaviour:
- Reset:
  - col, row, out_valid and frame_done go to 0; win0..win8 go to 0.
  - The 3x3 shift array is cleared. Line buffer RAM contents are not cleared; stale data is never emitted because output is gated by row >= 2.
  - Reset mid-frame abandons the frame. The next accepted pixel is treated as (0,0).
- Accept rule: on every clk with in_valid=1 and rst=0, the pixel at (row,col) is consumed. Cycles with in_valid=0 hold all state; out_valid=0 and frame_done=0 in those cycles.
- Line buffers:
  - lb_a holds row r-1 and lb_b holds row r-2, each IMG_W x DATA_W.
  - On accept at column c: read lb_a[c] and lb_b[c]; write lb_b[c] <= old lb_a[c] and lb_a[c] <= in_data in the same cycle. This is read-before-write on the same address.
- Shift array: 3 rows x 3 taps. On accept, each row shifts left one tap. New right-column taps are {old lb_b[c], old lb_a[c], in_data}.
- Counters:
  - col increments per accept; at IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1) both wrap to 0, so back-to-back frames need no idle cycle.
- Output:
  - If the accepted pixel has row >= 2 and col >= 2, then on the next clk win0..win8 present the window ending at that pixel and out_valid=1.
  - Latency is 1 cycle from accepting pixel (r,c) to its window.
  - Windows per frame: (IMG_H-2)*(IMG_W-2).
  - No windows are emitted for col 0/1 of any row or for rows 0/1, including the row-wrap cycles.
- Outputs hold their last value when out_valid=0.
- frame_done=1 in the same cycle as the out_valid for pixel (IMG_H-1, IMG_W-1).
- Arithmetic: pass-through only. Data is not modified, sign-extended or truncated.
- Simultaneous rst and in_valid: reset wins and the pixel is dropped.

Test Plan:
- Basic window: IMG_W=5, IMG_H=4, pixel = row*16+col, continuous in_valid.
  - Expect the first out_valid 1 cycle after accepting pixel 0x22, with win0..win8 = 00,01,02,10,11,12,20,21,22.
  - Expect exactly 6 windows, the last ending at 0x34, with frame_done=1 on that window only.
- Bubbles: same frame with in_valid toggling 1,0,0,1 pseudo-randomly.
  - Window contents and count must be identical to the basic case.
  - out_valid must never assert in a cycle following an in_valid=0 cycle.
- Row wrap: check no window ends at columns 0 or 1 (pixels 0x30, 0x31).
  - Window ending at 0x32 = 10,11,12,20,21,22,30,31,32, i.e. no cross-row contamination.
- Back-to-back frames: two frames, second with pixel = 0x80 + row*16 + col, no gap.
  - Second frame's first window = 80,81,82,90,91,92,A0,A1,A2.
  - Expect 12 windows and 2 frame_done pulses total.
- Reset mid-frame: assert rst for 1 cycle after pixel 0x23, then restart a fresh frame.
  - out_valid=0 and frame_done=0 during and after reset until pixel (2,2) of the new frame.
  - Windows then match the basic case exactly.
- Signed extremes: DATA_W=16, alternate pixels 0x7FFF and 0x8000.
  - Outputs must reproduce the inputs bit-exactly in window order.
